regfile_sb: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the pipelined and multi-issue cores. Decode/issue marks a destination register pending, and writeback clears it. Read ports return the register value plus a busy flag, which the hazard unit uses to stall or forward. Register 0 is hardwired to zero and never pending.

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 131 +++++++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Read, issue and writeback signals shared by the issue/writeback side and the
// scoreboarded register file.
interface regfile_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic                          issue_valid;
  logic [AW-1:0]                 issue_rd;
  logic                          issue_ready;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][AW-1:0]     wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                          err_underflow;

  modport master (
    output rd_addr, issue_valid, issue_rd, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, issue_ready, err_underflow
  );

  modport slave (
    input  rd_addr, issue_valid, issue_rd, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, issue_ready, err_underflow
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-write counters.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writebacks onto the read ports.
module regfile_sb_rdport #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 1,
  parameter int CNT_W    = 2
) (
  input  logic [$clog2(NUM_REGS)-1:0]                   addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]               data,
  input  logic [NUM_REGS-1:0][CNT_W-1:0]                pend,
  input  logic [NUM_WR-1:0]                             wr_en,
  input  logic [NUM_WR-1:0][$clog2(NUM_REGS)-1:0]       wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]                 wr_data,
  output logic [DATA_W-1:0]                             rd_data,
  output logic                                          rd_busy
);
  localparam int SW = CNT_W + $clog2(NUM_WR + 1) + 1;

`ifdef REGFILE_SB_BYPASS_EN
  logic [SW-1:0] nwr;

  // Highest-index hitting port wins, matching the write priority.
  always_comb begin
    rd_data = data[addr];
    nwr     = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && wr_addr[p] == addr) begin
        rd_data = wr_data[p];
        nwr     = nwr + SW'(1);
      end
    end
    rd_busy = SW'(pend[addr]) > nwr;
    if (addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    rd_data = data[addr];
    rd_busy = pend[addr] != '0;
    if (addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end
`endif
endmodule

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int SW = CNT_W + $clog2(NUM_WR + 1) + 1;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [NUM_REGS-1:0][DATA_W-1:0] data_q;
  logic [NUM_REGS-1:0][CNT_W-1:0]  pend_q, pend_d;
  logic [NUM_REGS-1:0]             uflow;
  logic                            err_q;
  logic                            fire;
  logic [SW-1:0]                   sum, nwr;

  // Ready looks only at the current count; a same-cycle writeback does not help.
  assign bus.issue_ready   = !((bus.issue_rd != '0) && (pend_q[bus.issue_rd] == PEND_MAX));
  assign fire              = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);
  assign bus.err_underflow = err_q;

  always_comb begin
    pend_d = pend_q;
    uflow  = '0;
    sum    = '0;
    nwr    = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      nwr = '0;
      for (int p = 0; p < NUM_WR; p++)
        if (bus.wr_en[p] && bus.wr_addr[p] == AW'(r)) nwr = nwr + SW'(1);
      sum = SW'(pend_q[r]) + SW'(fire && bus.issue_rd == AW'(r));
      // More writebacks than outstanding issues: clamp and flag.
      if (sum < nwr) begin
        pend_d[r] = '0;
        uflow[r]  = 1'b1;
      end else begin
        pend_d[r] = CNT_W'(sum - nwr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (|uflow) err_q <= 1'b1;
      for (int p = 0; p < NUM_WR; p++)
        if (bus.wr_en[p] && bus.wr_addr[p] != '0) data_q[bus.wr_addr[p]] <= bus.wr_data[p];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .NUM_WR  (NUM_WR),
      .CNT_W   (CNT_W)
    ) u_rd (
      .addr   (bus.rd_addr[i]),
      .data   (data_q),
      .pend   (pend_q),
      .wr_en  (bus.wr_en),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_data(bus.rd_data[i]),
      .rd_busy(bus.rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (two read, two write ports); expectations are
// queued as each step is driven and popped when the DUT output is sampled.
module tb_regfile_sb;
  localparam int DATA_W = 32, NUM_REGS = 32, NUM_RD = 2, NUM_WR = 2, CNT_W = 2;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  regfile_sb #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got %h", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_en[p]   = 1'b1;
    bus.wr_addr[p] = 5'(a);
    bus.wr_data[p] = d;
  endtask

  task automatic rd_check(input string tag, input int a, input logic [31:0] d, input bit b);
    bus.rd_addr[0] = 5'(a);
    bus.rd_addr[1] = 5'(a);
    #1;
    expect_val({tag, "_data0"}, 64'(d));
    expect_val({tag, "_data1"}, 64'(d));
    expect_val({tag, "_busy"}, 64'({b, b}));
    chk(64'(bus.rd_data[0]));
    chk(64'(bus.rd_data[1]));
    chk(64'(bus.rd_busy));
  endtask

  task automatic ready_check(input string tag, input int a, input bit r);
    bus.issue_rd = 5'(a);
    #1;
    expect_val(tag, 64'(r));
    chk(64'(bus.issue_ready));
  endtask

  task automatic err_check(input string tag, input bit v);
    #1;
    expect_val(tag, 64'(v));
    chk(64'(bus.err_underflow));
  endtask

  task automatic issue(input int a);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'(a);
    tick();
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    repeat (2) tick();
    rst = 1'b0;

    for (int r = 0; r < NUM_REGS; r++) begin
      rd_check("reset_rd", r, 32'h0, 1'b0);
      ready_check("reset_ready", r, 1'b1);
      tick();
    end
    err_check("reset_err", 1'b0);

    // Issue then writeback x5.
    issue(5);
    rd_check("x5_pending", 5, 32'h0, 1'b1);
    wr(0, 5, 32'hDEADBEEF);
    rd_check("x5_wb_same", 5, BYP ? 32'hDEADBEEF : 32'h0, !BYP);
    tick();
    idle();
    rd_check("x5_wb_after", 5, 32'hDEADBEEF, 1'b0);

    // Saturate x7's counter.
    for (int i = 0; i < 3; i++) begin
      ready_check("x7_ready_fill", 7, 1'b1);
      issue(7);
    end
    ready_check("x7_full", 7, 1'b0);
    bus.issue_valid = 1'b1;
    wr(0, 7, 32'h70);
    ready_check("x7_full_with_wb", 7, 1'b0);
    tick();
    idle();
    ready_check("x7_after_one_wb", 7, 1'b1);
    rd_check("x7_two_left", 7, 32'h70, 1'b1);
    wr(0, 7, 32'h71);
    tick();
    wr(0, 7, 32'h72);
    tick();
    idle();
    rd_check("x7_drained", 7, 32'h72, 1'b0);
    err_check("x7_no_err", 1'b0);

    // Register zero ignores issue and write.
    bus.issue_valid = 1'b1;
    wr(0, 0, 32'hFFFF);
    ready_check("x0_ready", 0, 1'b1);
    rd_check("x0_same", 0, 32'h0, 1'b0);
    tick();
    idle();
    rd_check("x0_after", 0, 32'h0, 1'b0);
    err_check("x0_no_err", 1'b0);

    // Same-cycle read of a write to x9.
    issue(9);
    wr(1, 9, 32'h1234);
    rd_check("x9_same", 9, BYP ? 32'h1234 : 32'h0, !BYP);
    tick();
    idle();
    rd_check("x9_after", 9, 32'h1234, 1'b0);
    bus.rd_addr[0] = 5'd7;
    bus.rd_addr[1] = 5'd9;
    #1;
    expect_val("split_port0", 64'h72);
    expect_val("split_port1", 64'h1234);
    chk(64'(bus.rd_data[0]));
    chk(64'(bus.rd_data[1]));

    // Two writebacks to x3 against one pending issue.
    issue(3);
    wr(0, 3, 32'hAAAA);
    wr(1, 3, 32'hBBBB);
    rd_check("x3_same", 3, BYP ? 32'hBBBB : 32'h0, !BYP);
    err_check("x3_err_before", 1'b0);
    tick();
    idle();
    rd_check("x3_after", 3, 32'hBBBB, 1'b0);
    err_check("x3_err_set", 1'b1);
    repeat (3) tick();
    err_check("x3_err_sticky", 1'b1);

    // Mid-operation reset drops state and the inputs of the reset cycle.
    issue(5);
    rst = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd6;
    wr(0, 6, 32'h66);
    tick();
    rst = 1'b0;
    idle();
    rd_check("rst_x5", 5, 32'h0, 1'b0);
    rd_check("rst_x6", 6, 32'h0, 1'b0);
    rd_check("rst_x3", 3, 32'h0, 1'b0);
    err_check("rst_err", 1'b0);
    ready_check("rst_ready", 7, 1'b1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
